wb_stage: RTL and testbench
===========================

# wb_stage

MEM/WB pipeline register and write-back selector for the 5-stage MIPS pipeline. It captures the MEM-stage result on each rising CLK edge and performs load byte/half extraction with sign/zero extension. It drives the register file write port (`rwd`, `wb_data`), which commits on the following falling edge, and mirrors the same pair to the forwarding unit. It also flags misaligned loads and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `CLK`  in  1  pipeline clock; state updates on posedge.
- `RST`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold the current MEM/WB contents.
- `flush`  in  1  capture a bubble instead of the MEM entry.
- `mem_valid`  in  1  MEM stage holds a real instruction.
- `mem_reg_write`  in  1  instruction writes a GPR.
- `mem_rd`  in  5  destination register.
- `mem_wb_sel`  in  2  result source: 0 ALU, 1 LOAD, 2 LINK, 3 reserved (treated as ALU).
- `mem_load_type`  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW; 5–7 treated as LW.
- `mem_addr_lo`  in  2  effective address bits [1:0].
- `mem_alu_res`  in  32  ALU result.
- `mem_load_data`  in  32  aligned data-memory word.
- `mem_pc8`  in  32  PC+8 link value.
- `rwd`  out  5  register file write index; 0 means no write.
- `wb_data`  out  32  register file write data.
- `wb_valid`  out  1  the registered entry is a real instruction.
- `wb_misalign`  out  1  the registered load is misaligned.
- `retired_count`  out  `CNT_W`  number of committed instructions.

## Operation
- Pipeline register fields: valid, reg_write, rd, wb_sel, load_type, addr_lo, alu_res, load_data, pc8.
- Capture priority on posedge CLK: `flush` over `stall`, and `stall` over a normal load.
  - `flush`: valid=0, reg_write=0. Other fields are don't-care.
  - `stall` only: all fields hold.
  - Otherwise: copy all `mem_*` inputs.
- Byte lanes are big-endian: addr_lo 0 selects [31:24] and addr_lo 3 selects [7:0]. Halfword addr_lo 0 selects [31:16] and addr_lo 2 selects [15:0].
- Misalignment:
  - LH/LHU with addr_lo[0]=1 is misaligned.
  - LW with addr_lo≠0 is misaligned.
  - Only applies when wb_sel=LOAD and valid=1.
- `wb_data` (combinational from registered state):
  - ALU selects alu_res.
  - LINK selects pc8.
  - LOAD selects the extended lane: LB/LH sign-extend, LBU/LHU zero-extend.
- `rwd` = rd when valid & reg_write & !misalign; otherwise 0. Writes to rd=0 therefore produce rwd=0.
- `wb_misalign` = valid & misaligned load.
- `retired_count` increments by 1 on a posedge that captures a MEM entry when that entry has mem_valid=1 and is not misaligned. This counts a stalled entry only once. The counter wraps at 2^CNT_W.

## Timing
- Latency: one cycle from MEM inputs to `rwd`/`wb_data`. The register file commits on the falling edge of the same cycle, so an ID read in that cycle's second half sees the new value.
- Under `stall`, `rwd`/`wb_data` stay constant. The repeated falling-edge rewrite is idempotent.
- Reset values:
  - valid=0 and reg_write=0, so `rwd`=0, `wb_valid`=0 and `wb_misalign`=0.
  - `wb_data`=0: alu_res=0 and wb_sel=ALU.
  - `retired_count`=0.
- Reset takes effect immediately, mid-cycle, regardless of `stall`/`flush`. An entry already in flight is dropped without counting.
- `stall` and `flush` asserted together: `flush` wins and a bubble is inserted.

## Structure
- Shared `def.v` holds:
  - `WB_ALU`/`WB_LOAD`/`WB_LINK`.
  - `LD_LB`/`LD_LBU`/`LD_LH`/`LD_LHU`/`LD_LW` encodings.
  - `REG_ZERO`.
- Sub-module `load_extend`: combinational lane select and extension (inputs: data, addr_lo, load_type; output: 32-bit value). It is reused by any future LWL/LWR work.

## Test plan
- Reset mid-cycle with a valid ALU entry loaded → `rwd`=0, `wb_data`=0, `retired_count`=0 immediately.
- load_data=0x8899AABB:
  - LB addr 1 → 0xFFFFFF99.
  - LBU addr 3 → 0x000000BB.
  - LH addr 2 → 0xFFFFAABB.
  - LHU addr 0 → 0x00008899.
  - LW addr 0 → 0x8899AABB.
  - Each with `rwd`=rd.
- LW addr_lo=2, rd=8 → `rwd`=0, `wb_misalign`=1, counter unchanged. LH addr_lo=1 gives the same result.
- ALU write with rd=0, alu_res=5 → `rwd`=0. The counter increments by 1.
- Hold `stall` for 3 cycles on a LINK entry (pc8=0x00400010, rd=31) → `rwd`=31 and `wb_data` stable for 4 cycles. The counter increments only once.
- Assert `stall`+`flush` together with a valid entry on the inputs → next cycle `wb_valid`=0 and `rwd`=0. Counting continues correctly after the bubble.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared write-back encodings and the load misalignment rule for the MEM/WB stage.
package wb_stage_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LW  = 3'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Encodings 5-7 of load_type behave as LW, so they fall into the default arm.
    function automatic logic load_misaligned(input logic [1:0] wb_sel,
                                             input logic [2:0] load_type,
                                             input logic [1:0] addr_lo);
        logic m;
        m = 1'b0;
        if (wb_sel == WB_LOAD) begin
            case (load_type)
                LD_LB, LD_LBU: m = 1'b0;
                LD_LH, LD_LHU: m = addr_lo[0];
                default:       m = (addr_lo != 2'd0);
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_stage_load_extend.sv
// Big-endian byte/halfword lane select with sign or zero extension for loads.
module load_extend
    import wb_stage_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_type,
    output logic [31:0] value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = data[31:24];
            2'd1:    byte_lane = data[23:16];
            2'd2:    byte_lane = data[15:8];
            default: byte_lane = data[7:0];
        endcase
        half_lane = addr_lo[1] ? data[15:0] : data[31:16];
    end

    always_comb begin
        case (load_type)
            LD_LB:   value = {{24{byte_lane[7]}}, byte_lane};
            LD_LBU:  value = {24'd0, byte_lane};
            LD_LH:   value = {{16{half_lane[15]}}, half_lane};
            LD_LHU:  value = {16'd0, half_lane};
            default: value = data;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, write-back data select, misaligned-load flag and retire counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_load_type,
    input  logic [1:0]       mem_addr_lo,
    input  logic [31:0]      mem_alu_res,
    input  logic [31:0]      mem_load_data,
    input  logic [31:0]      mem_pc8,
    output logic [4:0]       rwd,
    output logic [31:0]      wb_data,
    output logic             wb_valid,
    output logic             wb_misalign,
    output logic [CNT_W-1:0] retired_count
);

    logic        valid_q;
    logic        reg_write_q;
    logic [4:0]  rd_q;
    logic [1:0]  wb_sel_q;
    logic [2:0]  load_type_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] alu_res_q;
    logic [31:0] load_data_q;
    logic [31:0] pc8_q;
    logic [31:0] load_value;
    logic        mem_misalign;
    logic        wb_mis_raw;

    assign mem_misalign = load_misaligned(mem_wb_sel, mem_load_type, mem_addr_lo);

    // A flushed bubble only needs valid/reg_write cleared; the datapath fields just hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            rd_q          <= REG_ZERO;
            wb_sel_q      <= WB_ALU;
            load_type_q   <= LD_LW;
            addr_lo_q     <= 2'd0;
            alu_res_q     <= 32'd0;
            load_data_q   <= 32'd0;
            pc8_q         <= 32'd0;
            retired_count <= '0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= mem_valid;
            reg_write_q <= mem_reg_write;
            rd_q        <= mem_rd;
            wb_sel_q    <= mem_wb_sel;
            load_type_q <= mem_load_type;
            addr_lo_q   <= mem_addr_lo;
            alu_res_q   <= mem_alu_res;
            load_data_q <= mem_load_data;
            pc8_q       <= mem_pc8;
            if (mem_valid && !mem_misalign)
                retired_count <= retired_count + CNT_W'(1);
        end
    end

    load_extend u_load_extend (
        .data      (load_data_q),
        .addr_lo   (addr_lo_q),
        .load_type (load_type_q),
        .value     (load_value)
    );

    assign wb_mis_raw  = load_misaligned(wb_sel_q, load_type_q, addr_lo_q);
    assign wb_misalign = valid_q & wb_mis_raw;
    assign wb_valid    = valid_q;
    assign rwd         = (valid_q && reg_write_q && !wb_mis_raw) ? rd_q : REG_ZERO;

    always_comb begin
        case (wb_sel_q)
            WB_LOAD: wb_data = load_value;
            WB_LINK: wb_data = pc8_q;
            default: wb_data = alu_res_q;
        endcase
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for wb_stage: loads, misalignment, stall/flush, reset.
module tb_wb_stage;

    logic        CLK;
    logic        RST;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_load_data;
    logic [31:0] mem_pc8;
    logic [4:0]  rwd;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic        wb_misalign;
    logic [31:0] retired_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    typedef struct {
        logic [4:0]  rwd;
        logic [31:0] data;
        logic        chk_data;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    wb_stage #(.CNT_W(32)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .stall         (stall),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_wb_sel    (mem_wb_sel),
        .mem_load_type (mem_load_type),
        .mem_addr_lo   (mem_addr_lo),
        .mem_alu_res   (mem_alu_res),
        .mem_load_data (mem_load_data),
        .mem_pc8       (mem_pc8),
        .rwd           (rwd),
        .wb_data       (wb_data),
        .wb_valid      (wb_valid),
        .wb_misalign   (wb_misalign),
        .retired_count (retired_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Drive one MEM entry at a negedge, push its expectation, then compare at the next negedge.
    task automatic issue(input string tag,
                         input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] a,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc8,
                         input logic st, input logic fl,
                         input logic [4:0] e_rwd, input logic [31:0] e_data, input logic e_chk,
                         input logic e_valid, input logic e_mis, input logic inc);
        exp_t e;
        mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
        mem_load_type = lt; mem_addr_lo = a; mem_alu_res = alu;
        mem_load_data = ld; mem_pc8 = pc8; stall = st; flush = fl;
        e.rwd = e_rwd; e.data = e_data; e.chk_data = e_chk; e.valid = e_valid; e.mis = e_mis;
        sb.push_back(e);
        if (inc) exp_cnt = exp_cnt + 32'd1;
        @(posedge CLK);
        @(negedge CLK);
        e = sb.pop_front();
        check({tag, ".rwd"}, {27'd0, rwd}, {27'd0, e.rwd});
        if (e.chk_data) check({tag, ".wb_data"}, wb_data, e.data);
        check({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, e.valid});
        check({tag, ".wb_misalign"}, {31'd0, wb_misalign}, {31'd0, e.mis});
        check({tag, ".retired_count"}, retired_count, exp_cnt);
    endtask

    initial begin
        RST = 1'b1; stall = 1'b0; flush = 1'b0;
        mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = 5'd0; mem_wb_sel = 2'd0;
        mem_load_type = 3'd0; mem_addr_lo = 2'd0; mem_alu_res = 32'd0;
        mem_load_data = 32'd0; mem_pc8 = 32'd0;
        @(negedge CLK);
        check("reset.rwd", {27'd0, rwd}, 32'd0);
        check("reset.wb_data", wb_data, 32'd0);
        check("reset.wb_valid", {31'd0, wb_valid}, 32'd0);
        check("reset.wb_misalign", {31'd0, wb_misalign}, 32'd0);
        check("reset.retired_count", retired_count, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Load lane extraction from 0x8899AABB
        issue("lb_a1",  1,1,5'd1, 2'd1,3'd0,2'd1, 32'h0,32'h8899AABB,32'h0, 0,0, 5'd1, 32'hFFFFFF99,1,1,0,1);
        issue("lbu_a3", 1,1,5'd2, 2'd1,3'd1,2'd3, 32'h0,32'h8899AABB,32'h0, 0,0, 5'd2, 32'h000000BB,1,1,0,1);
        issue("lh_a2",  1,1,5'd3, 2'd1,3'd2,2'd2, 32'h0,32'h8899AABB,32'h0, 0,0, 5'd3, 32'hFFFFAABB,1,1,0,1);
        issue("lhu_a0", 1,1,5'd4, 2'd1,3'd3,2'd0, 32'h0,32'h8899AABB,32'h0, 0,0, 5'd4, 32'h00008899,1,1,0,1);
        issue("lw_a0",  1,1,5'd5, 2'd1,3'd4,2'd0, 32'h0,32'h8899AABB,32'h0, 0,0, 5'd5, 32'h8899AABB,1,1,0,1);
        issue("lt6_lw", 1,1,5'd6, 2'd1,3'd6,2'd0, 32'h0,32'h11223344,32'h0, 0,0, 5'd6, 32'h11223344,1,1,0,1);
        issue("lb_a0",  1,1,5'd7, 2'd1,3'd0,2'd0, 32'h0,32'h7F00FF00,32'h0, 0,0, 5'd7, 32'h0000007F,1,1,0,1);

        // Misaligned loads: no write, flag set, not counted
        issue("lw_mis", 1,1,5'd8, 2'd1,3'd4,2'd2, 32'h0,32'h8899AABB,32'h0, 0,0, 5'd0, 32'h0,0,1,1,0);
        issue("lh_mis", 1,1,5'd8, 2'd1,3'd2,2'd1, 32'h0,32'h8899AABB,32'h0, 0,0, 5'd0, 32'h0,0,1,1,0);
        issue("lbu_odd",1,1,5'd8, 2'd1,3'd1,2'd1, 32'h0,32'h8899AABB,32'h0, 0,0, 5'd8, 32'h00000099,1,1,0,1);

        // ALU to r0, reserved wb_sel, invalid entry
        issue("alu_r0", 1,1,5'd0, 2'd0,3'd0,2'd0, 32'd5,32'h0,32'h0, 0,0, 5'd0, 32'd5,1,1,0,1);
        issue("sel3",   1,1,5'd9, 2'd3,3'd4,2'd3, 32'hCAFE0001,32'h0,32'h0, 0,0, 5'd9, 32'hCAFE0001,1,1,0,1);
        issue("invalid",0,1,5'd10,2'd0,3'd0,2'd0, 32'h00000042,32'h0,32'h0, 0,0, 5'd0, 32'h00000042,1,0,0,0);

        // LINK entry held by a 3-cycle stall while the inputs change underneath
        issue("link",   1,1,5'd31,2'd2,3'd0,2'd0, 32'h0,32'h0,32'h00400010, 0,0, 5'd31,32'h00400010,1,1,0,1);
        for (int i = 0; i < 3; i++)
            issue("stall",1,1,5'd12,2'd0,3'd0,2'd0, 32'h0BAD0000+i,32'h0,32'h0, 1,0, 5'd31,32'h00400010,1,1,0,0);

        // stall+flush together inserts a bubble; counting resumes afterwards
        issue("st_fl",  1,1,5'd13,2'd0,3'd0,2'd0, 32'h0000BEEF,32'h0,32'h0, 1,1, 5'd0, 32'h0,0,0,0,0);
        issue("after",  1,1,5'd14,2'd0,3'd0,2'd0, 32'h00001234,32'h0,32'h0, 0,0, 5'd14,32'h00001234,1,1,0,1);

        // Asynchronous reset mid-cycle with a valid entry loaded
        issue("pre_rst",1,1,5'd15,2'd0,3'd0,2'd0, 32'h0000DEAD,32'h0,32'h0, 0,0, 5'd15,32'h0000DEAD,1,1,0,1);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("midrst.rwd", {27'd0, rwd}, 32'd0);
        check("midrst.wb_data", wb_data, 32'd0);
        check("midrst.wb_valid", {31'd0, wb_valid}, 32'd0);
        check("midrst.retired_count", retired_count, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
